multi_digit_counter_7seg: RTL and testbench

//   Parametrised multi-digit up/down counter with per-digit 7-segment decode for the DE1 lab boards.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_decode.sv | 17 +
 rtl/multi_digit_counter_7seg.sv | 126 ++++++++++++
 tb/tb_multi_digit_counter_7seg.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the DE1 7-segment display blocks.
//   SEG_BLANK        all segments off (active-low)
//   SEG_TABLE[v]     active-low {g,f,e,d,c,b,a} pattern for hex digit v
//   DEC_MAX/HEX_MAX  largest digit value in BCD / hex counting
//   digit_max()      active per-digit maximum for the selected mode
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DEC_MAX = 4'd9;
  localparam logic [3:0] HEX_MAX = 4'hF;

  // Entry 15 first so that SEG_TABLE[v] selects the pattern for value v.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [3:0] digit_max(input logic dec_mode);
    return dec_mode ? DEC_MAX : HEX_MAX;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: one 4-bit digit to active-low 7-segment pattern.
//   value  in  4  digit value 0..F
//   blank  in  1  1 = all segments off
//   seg    out 7  active-low {g,f,e,d,c,b,a}
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : SEG_TABLE[value];
  end

endmodule

// File: rtl/multi_digit_counter_7seg.sv
// multi_digit_counter_7seg: multi-digit up/down counter, hex or BCD per digit, with a
// 7-segment decoder per digit and optional leading-zero blanking.
//   clk       in   1          clock, rising edge
//   rst       in   1          asynchronous active-high reset
//   en        in   1          count enable
//   up        in   1          1 = up, 0 = down
//   dec_mode  in   1          1 = BCD digits (0..9), 0 = hex digits (0..F)
//   load      in   1          synchronous load of load_val (wins over en)
//   load_val  in   4*DIGITS   load value, digit i = load_val[4i+3:4i]
//   blank_lz  in   1          blank leading zero digits (digit 0 never blanked)
//   count     out  4*DIGITS   registered count
//   tc        out  1          registered one-cycle pulse after a full-counter wrap
//   hex       out  7*DIGITS   active-low segments, digit i = hex[7i+6:7i]
module multi_digit_counter_7seg
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  dec_mode,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic [7*DIGITS-1:0]   hex
);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                tc_q, tc_d;

  logic [DIGITS-1:0]   at_max;
  logic [DIGITS-1:0]   at_zero;
  logic [DIGITS-1:0]   step;
  logic [DIGITS-1:0]   digit_blank;
  logic                chain;
  logic                wrap;
  logic                zero_run;
  logic [3:0]          max_val;

  assign max_val = digit_max(dec_mode);

  // In BCD mode an out-of-range digit (A..F) behaves as MAX on the way up.
  always_comb begin
    at_max  = '0;
    at_zero = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      at_max[i]  = dec_mode ? (count_q[4*i +: 4] >= DEC_MAX) : (count_q[4*i +: 4] == HEX_MAX);
      at_zero[i] = (count_q[4*i +: 4] == 4'd0);
    end
  end

  // Prefix AND: digit i steps when every lower digit is at MAX (up) or 0 (down).
  // The chain surviving past the top digit means the whole counter wraps.
  always_comb begin
    chain = 1'b1;
    step  = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      step[i] = chain;
      chain   = chain & (up ? at_max[i] : at_zero[i]);
    end
    wrap = chain;
  end

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        count_d[4*i +: 4] = (dec_mode && (load_val[4*i +: 4] > DEC_MAX)) ? DEC_MAX
                                                                          : load_val[4*i +: 4];
      end
    end else if (en) begin
      tc_d = wrap;
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (step[i]) begin
          if (up) begin
            count_d[4*i +: 4] = at_max[i] ? 4'd0 : count_q[4*i +: 4] + 4'd1;
          end else if (at_zero[i]) begin
            count_d[4*i +: 4] = max_val;
          end else if (dec_mode && (count_q[4*i +: 4] > DEC_MAX)) begin
            // Out-of-range BCD digit drops straight to 9; not a borrow.
            count_d[4*i +: 4] = DEC_MAX;
          end else begin
            count_d[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

  // Walk from the top digit down; a digit is a leading zero while all digits above are zero.
  always_comb begin
    digit_blank = '0;
    zero_run    = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run       = zero_run & at_zero[i];
      digit_blank[i] = blank_lz && (i > 0) && zero_run;
    end
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    seg7_decode u_decode (
      .value (count_q[4*g +: 4]),
      .blank (digit_blank[g]),
      .seg   (hex[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_multi_digit_counter_7seg.sv
module tb_multi_digit_counter_7seg;

  logic        clk = 1'b0;
  logic        rst, en, up, dec_mode, load, blank_lz;
  logic [7:0]  load_val;
  logic [7:0]  count2;
  logic        tc2;
  logic [13:0] hex2;

  logic        load4, en4;
  logic [15:0] load_val4;
  logic [15:0] count4;
  logic        tc4;
  logic [27:0] hex4;

  bit   clk_run = 1'b1;
  int   cyc = 0;
  event mon_tick;

  typedef struct {
    int          due;
    bit          wide;
    logic [15:0] cnt;
    logic        tc;
    logic [27:0] hx;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  multi_digit_counter_7seg #(.DIGITS(2)) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .dec_mode (dec_mode),
    .load     (load),
    .load_val (load_val),
    .blank_lz (blank_lz),
    .count    (count2),
    .tc       (tc2),
    .hex      (hex2)
  );

  multi_digit_counter_7seg #(.DIGITS(4)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .en       (en4),
    .up       (up),
    .dec_mode (dec_mode),
    .load     (load4),
    .load_val (load_val4),
    .blank_lz (blank_lz),
    .count    (count4),
    .tc       (tc4),
    .hex      (hex4)
  );

  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) -> mon_tick;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [27:0] exp_hex(input logic [15:0] c, input int nd, input logic bl);
    logic [27:0] r;
    logic        zero_up;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      zero_up = 1'b1;
      for (int j = i; j < nd; j++) if (c[4*j +: 4] != 4'd0) zero_up = 1'b0;
      r[7*i +: 7] = (bl && i > 0 && zero_up) ? 7'b1111111 : seg_of(c[4*i +: 4]);
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
  endtask

  task automatic push(input int due, input bit wide, input logic [15:0] c, input logic t,
                      input logic [27:0] hx, input string nm);
    exp_t e;
    e.due = due; e.wide = wide; e.cnt = c; e.tc = t; e.hx = hx; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every expected entry that falls due on this sample point.
  always @(mon_tick) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.wide) begin
        check({e.name, ".count"}, {16'h0, count4}, {16'h0, e.cnt});
        check({e.name, ".tc"}, {31'h0, tc4}, {31'h0, e.tc});
        check({e.name, ".hex"}, {4'h0, hex4}, {4'h0, e.hx});
      end else begin
        check({e.name, ".count"}, {24'h0, count2}, {16'h0, e.cnt});
        check({e.name, ".tc"}, {31'h0, tc2}, {31'h0, e.tc});
        check({e.name, ".hex"}, {18'h0, hex2}, {4'h0, e.hx});
      end
    end
  end

  // Drive inputs just after a negedge; the result is due after the next posedge.
  task automatic step2(input logic ld, input logic [7:0] lv, input logic e, input logic u,
                       input logic dm, input logic bl, input logic [7:0] ec, input logic et,
                       input string nm);
    @(negedge clk);
    #1;
    load = ld; load_val = lv; en = e; up = u; dec_mode = dm; blank_lz = bl; load4 = 1'b0;
    push(cyc + 1, 1'b0, {8'h00, ec}, et, exp_hex({8'h00, ec}, 2, bl), nm);
  endtask

  task automatic step4(input logic [15:0] lv, input logic bl, input logic [27:0] hx,
                       input string nm);
    @(negedge clk);
    #1;
    load = 1'b0; en = 1'b0; blank_lz = bl; load4 = 1'b1; load_val4 = lv;
    push(cyc + 1, 1'b1, lv, 1'b0, hx, nm);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; dec_mode = 1'b0; load = 1'b0; load_val = '0;
    blank_lz = 1'b0; load4 = 1'b0; en4 = 1'b0; load_val4 = '0;
    #1;
    push(cyc + 1, 1'b0, 16'h0, 1'b0, {14'h0, 14'b1000000_1000000}, "reset2");
    push(cyc + 1, 1'b1, 16'h0, 1'b0, 28'b1000000_1000000_1000000_1000000, "reset4");
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Asynchronous reset while counting at 37, with the clock stopped.
    step2(1'b1, 8'h36, 1'b0, 1'b1, 1'b0, 1'b0, 8'h36, 1'b0, "load_36");
    step2(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h37, 1'b0, "up_37");
    @(negedge clk);
    #1;
    clk_run = 1'b0;
    rst = 1'b1;
    #2;
    push(cyc, 1'b0, 16'h0, 1'b0, {14'h0, 14'b1000000_1000000}, "async_rst");
    -> mon_tick;
    #2;
    rst = 1'b0;
    en  = 1'b0;
    clk_run = 1'b1;

    // BCD up through the full wrap.
    step2(1'b1, 8'h98, 1'b0, 1'b1, 1'b1, 1'b0, 8'h98, 1'b0, "load_98");
    step2(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h99, 1'b0, "bcd_99");
    step2(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, "bcd_wrap_up");
    step2(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, "bcd_01");

    // Hex down with borrow and full wrap.
    step2(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, "load_10");
    step2(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b0, "borrow_0f");
    step2(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0E, 1'b0, "down_0e");
    step2(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "load_00");
    step2(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, "hex_wrap_down");
    step2(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b0, "down_fe");

    // Load beats a would-be wrap; BCD clamp on load.
    step2(1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 1'b0, 8'h99, 1'b0, "load_99");
    step2(1'b1, 8'hC5, 1'b1, 1'b1, 1'b1, 1'b0, 8'h95, 1'b0, "load_clamp");

    // Mode switch with an out-of-range digit.
    step2(1'b1, 8'h0C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0C, 1'b0, "load_0c");
    step2(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 1'b0, "switch_up");
    step2(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, "bcd_11");
    step2(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, "hold");
    step2(1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0C, 1'b0, "load_0c_b");
    step2(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h09, 1'b0, "switch_down");

    // Leading-zero blanking on two digits.
    step2(1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0, "blank_05");
    step2(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, "blank_00");
    step2(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h99, 1'b1, "bcd_wrap_down");

    // Four digits: blanking of the upper two digits of 0050.
    step4(16'h0050, 1'b1, 28'b1111111_1111111_0010010_1000000, "d4_blank");
    step4(16'h0050, 1'b0, 28'b1000000_1000000_0010010_1000000, "d4_noblank");

    repeat (3) @(negedge clk);
    #1;
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      $display("FAIL %s: never sampled, expected count %h", e.name, e.cnt);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
